// File: rtl/rs_age_multi_cdb.sv
// Unified reservation station with an age-matrix oldest-ready issue.
// Operands wake from NUM_CDB buses, with bypass into the dispatching entry.
module rs_age_multi_cdb #(
    parameter int DATA_WIDTH     = 32,
    parameter int OPCODE_WIDTH   = 32,
    parameter int RS_SIZE        = 8,
    parameter int ROB_ADDR_WIDTH = 5,
    parameter int NUM_CDB        = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               flush_i,
    input  logic                               dispatch_valid_i,
    output logic                               dispatch_ready_o,
    input  logic [OPCODE_WIDTH-1:0]            dispatch_opcode_i,
    input  logic [DATA_WIDTH-1:0]              dispatch_v_rs1_i,
    input  logic [DATA_WIDTH-1:0]              dispatch_v_rs2_i,
    input  logic                               dispatch_q_rs1_valid_i,
    input  logic                               dispatch_q_rs2_valid_i,
    input  logic [ROB_ADDR_WIDTH-1:0]          dispatch_q_rs1_i,
    input  logic [ROB_ADDR_WIDTH-1:0]          dispatch_q_rs2_i,
    input  logic [ROB_ADDR_WIDTH-1:0]          dispatch_rob_tag_i,
    input  logic [NUM_CDB-1:0]                 cdb_valid_i,
    input  logic [NUM_CDB*ROB_ADDR_WIDTH-1:0]  cdb_rob_tag_i,
    input  logic [NUM_CDB*DATA_WIDTH-1:0]      cdb_data_i,
    output logic                               issue_valid_o,
    input  logic                               issue_ready_i,
    output logic [OPCODE_WIDTH-1:0]            issue_opcode_o,
    output logic [DATA_WIDTH-1:0]              issue_v_rs1_o,
    output logic [DATA_WIDTH-1:0]              issue_v_rs2_o,
    output logic [ROB_ADDR_WIDTH-1:0]          issue_rob_tag_o,
    output logic [$clog2(RS_SIZE+1)-1:0]       occupancy_o,
    output logic                               empty_o
);

    localparam int OCC_W = $clog2(RS_SIZE + 1);
    localparam int IDX_W = $clog2(RS_SIZE);
    localparam logic [OCC_W-1:0] L_FULL = OCC_W'(RS_SIZE);

    logic [RS_SIZE-1:0]        r_busy;
    logic [RS_SIZE-1:0]        r_q1v;
    logic [RS_SIZE-1:0]        r_q2v;
    logic [OPCODE_WIDTH-1:0]   r_op  [RS_SIZE];
    logic [DATA_WIDTH-1:0]     r_v1  [RS_SIZE];
    logic [DATA_WIDTH-1:0]     r_v2  [RS_SIZE];
    logic [ROB_ADDR_WIDTH-1:0] r_q1  [RS_SIZE];
    logic [ROB_ADDR_WIDTH-1:0] r_q2  [RS_SIZE];
    logic [ROB_ADDR_WIDTH-1:0] r_tag [RS_SIZE];
    logic [RS_SIZE-1:0]        r_older [RS_SIZE];
    logic [OCC_W-1:0]          r_occ;

    logic [RS_SIZE-1:0]        w_ready;
    logic [RS_SIZE-1:0]        w_col [RS_SIZE];
    logic [RS_SIZE-1:0]        w_sel_oh;
    logic [IDX_W-1:0]          w_sel_idx;
    logic [IDX_W-1:0]          w_alloc_idx;
    logic                      w_issue_valid;
    logic                      w_dacc;
    logic                      w_iacc;

    logic [DATA_WIDTH-1:0]     w_n_v1 [RS_SIZE];
    logic [DATA_WIDTH-1:0]     w_n_v2 [RS_SIZE];
    logic [RS_SIZE-1:0]        w_n_q1v;
    logic [RS_SIZE-1:0]        w_n_q2v;

    logic [DATA_WIDTH-1:0]     w_d_v1;
    logic [DATA_WIDTH-1:0]     w_d_v2;
    logic                      w_d_q1v;
    logic                      w_d_q2v;

    assign dispatch_ready_o = (r_occ < L_FULL);
    assign occupancy_o      = r_occ;
    assign empty_o          = (r_occ == '0);
    assign w_ready          = r_busy & ~r_q1v & ~r_q2v;
    assign w_issue_valid    = |w_ready;
    assign w_dacc           = dispatch_valid_i & dispatch_ready_o;
    assign w_iacc           = w_issue_valid & issue_ready_i;

    // Oldest ready entry: no other ready entry is older than it.
    always_comb begin
        w_sel_idx = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            w_col[i] = '0;
            for (int j = 0; j < RS_SIZE; j++) begin
                w_col[i][j] = r_older[j][i];
            end
            w_sel_oh[i] = w_ready[i] & ~|(w_ready & w_col[i]);
        end
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (w_sel_oh[i]) begin
                w_sel_idx = IDX_W'(i);
            end
        end
    end

    // Lowest-index free entry receives the next dispatch.
    always_comb begin
        w_alloc_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_alloc_idx = IDX_W'(i);
            end
        end
    end

    // Issue outputs, zeroed when nothing is ready.
    always_comb begin
        issue_valid_o   = w_issue_valid;
        issue_opcode_o  = '0;
        issue_v_rs1_o   = '0;
        issue_v_rs2_o   = '0;
        issue_rob_tag_o = '0;
        if (w_issue_valid) begin
            issue_opcode_o  = r_op[w_sel_idx];
            issue_v_rs1_o   = r_v1[w_sel_idx];
            issue_v_rs2_o   = r_v2[w_sel_idx];
            issue_rob_tag_o = r_tag[w_sel_idx];
        end
    end

    // Wakeup of stored operands; descending scan lets the lowest bus win.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            w_n_v1[i]  = r_v1[i];
            w_n_v2[i]  = r_v2[i];
            w_n_q1v[i] = r_q1v[i];
            w_n_q2v[i] = r_q2v[i];
            for (int k = NUM_CDB - 1; k >= 0; k--) begin
                if (cdb_valid_i[k] && r_q1v[i] &&
                    cdb_rob_tag_i[k*ROB_ADDR_WIDTH +: ROB_ADDR_WIDTH] == r_q1[i]) begin
                    w_n_v1[i]  = cdb_data_i[k*DATA_WIDTH +: DATA_WIDTH];
                    w_n_q1v[i] = 1'b0;
                end
                if (cdb_valid_i[k] && r_q2v[i] &&
                    cdb_rob_tag_i[k*ROB_ADDR_WIDTH +: ROB_ADDR_WIDTH] == r_q2[i]) begin
                    w_n_v2[i]  = cdb_data_i[k*DATA_WIDTH +: DATA_WIDTH];
                    w_n_q2v[i] = 1'b0;
                end
            end
        end
    end

    // Same-cycle bypass of CDB results into the dispatching operands.
    always_comb begin
        w_d_v1  = dispatch_v_rs1_i;
        w_d_v2  = dispatch_v_rs2_i;
        w_d_q1v = dispatch_q_rs1_valid_i;
        w_d_q2v = dispatch_q_rs2_valid_i;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (cdb_valid_i[k] && dispatch_q_rs1_valid_i &&
                cdb_rob_tag_i[k*ROB_ADDR_WIDTH +: ROB_ADDR_WIDTH] == dispatch_q_rs1_i) begin
                w_d_v1  = cdb_data_i[k*DATA_WIDTH +: DATA_WIDTH];
                w_d_q1v = 1'b0;
            end
            if (cdb_valid_i[k] && dispatch_q_rs2_valid_i &&
                cdb_rob_tag_i[k*ROB_ADDR_WIDTH +: ROB_ADDR_WIDTH] == dispatch_q_rs2_i) begin
                w_d_v2  = cdb_data_i[k*DATA_WIDTH +: DATA_WIDTH];
                w_d_q2v = 1'b0;
            end
        end
    end

    // Entry state, age matrix and occupancy; flush frees everything.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_busy <= '0;
            r_q1v  <= '0;
            r_q2v  <= '0;
            r_occ  <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                r_op[i]    <= '0;
                r_v1[i]    <= '0;
                r_v2[i]    <= '0;
                r_q1[i]    <= '0;
                r_q2[i]    <= '0;
                r_tag[i]   <= '0;
                r_older[i] <= '0;
            end
        end else if (flush_i) begin
            r_busy <= '0;
            r_occ  <= '0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                r_v1[i]  <= w_n_v1[i];
                r_v2[i]  <= w_n_v2[i];
                r_q1v[i] <= w_n_q1v[i];
                r_q2v[i] <= w_n_q2v[i];
            end
            if (w_iacc) begin
                r_busy[w_sel_idx] <= 1'b0;
            end
            if (w_dacc) begin
                r_busy[w_alloc_idx] <= 1'b1;
                r_op[w_alloc_idx]   <= dispatch_opcode_i;
                r_v1[w_alloc_idx]   <= w_d_v1;
                r_v2[w_alloc_idx]   <= w_d_v2;
                r_q1v[w_alloc_idx]  <= w_d_q1v;
                r_q2v[w_alloc_idx]  <= w_d_q2v;
                r_q1[w_alloc_idx]   <= dispatch_q_rs1_i;
                r_q2[w_alloc_idx]   <= dispatch_q_rs2_i;
                r_tag[w_alloc_idx]  <= dispatch_rob_tag_i;
                for (int j = 0; j < RS_SIZE; j++) begin
                    r_older[j][w_alloc_idx] <= r_busy[j];
                end
                r_older[w_alloc_idx] <= '0;
            end
            unique case ({w_dacc, w_iacc})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

// File: tb/tb_rs_age_multi_cdb.sv
// Bench for rs_age_multi_cdb: dispatch-ordered queue model plus
// directed vectors with literal expectations.
module tb_rs_age_multi_cdb;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b1;
    logic        flush;
    logic        dv;
    logic        dready;
    logic [31:0] dop, dv1, dv2;
    logic        dq1v, dq2v;
    logic [4:0]  dq1, dq2, dtag;
    logic [1:0]  cv;
    logic [9:0]  ctag;
    logic [63:0] cdata;
    logic        iv, ir;
    logic [31:0] iop, iv1, iv2;
    logic [4:0]  itag;
    logic [3:0]  occ;
    logic        empty;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] op, v1, v2;
        bit          q1v, q2v;
        logic [4:0]  q1, q2, tag;
    } ent_t;

    ent_t mq[$];

    rs_age_multi_cdb dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush),
        .dispatch_valid_i(dv), .dispatch_ready_o(dready),
        .dispatch_opcode_i(dop),
        .dispatch_v_rs1_i(dv1), .dispatch_v_rs2_i(dv2),
        .dispatch_q_rs1_valid_i(dq1v), .dispatch_q_rs2_valid_i(dq2v),
        .dispatch_q_rs1_i(dq1), .dispatch_q_rs2_i(dq2),
        .dispatch_rob_tag_i(dtag),
        .cdb_valid_i(cv), .cdb_rob_tag_i(ctag), .cdb_data_i(cdata),
        .issue_valid_o(iv), .issue_ready_i(ir),
        .issue_opcode_o(iop), .issue_v_rs1_o(iv1), .issue_v_rs2_o(iv2),
        .issue_rob_tag_o(itag), .occupancy_o(occ), .empty_o(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    function automatic ent_t wake(input ent_t e);
        ent_t r = e;
        for (int k = 0; k < 2; k++) begin
            if (cv[k] && r.q1v && ctag[k*5 +: 5] == r.q1) begin
                r.v1 = cdata[k*32 +: 32];
                r.q1v = 0;
            end
            if (cv[k] && r.q2v && ctag[k*5 +: 5] == r.q2) begin
                r.v2 = cdata[k*32 +: 32];
                r.q2v = 0;
            end
        end
        return r;
    endfunction

    function automatic int msel();
        foreach (mq[i]) if (!mq[i].q1v && !mq[i].q2v) return i;
        return -1;
    endfunction

    // Model: oldest-first queue stepped on each clock edge.
    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            mq.delete();
        end else begin
            int s;
            bit dacc, iacc;
            ent_t e;
            s = msel();
            dacc = dv && (mq.size() < 8);
            iacc = (s >= 0) && ir;
            if (flush) begin
                mq.delete();
            end else begin
                if (iacc) mq.delete(s);
                foreach (mq[i]) mq[i] = wake(mq[i]);
                if (dacc) begin
                    e.op = dop; e.v1 = dv1; e.v2 = dv2;
                    e.q1v = dq1v; e.q2v = dq2v;
                    e.q1 = dq1; e.q2 = dq2; e.tag = dtag;
                    mq.push_back(wake(e));
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        int s;
        s = msel();
        chk("m_valid", 32'(iv), 32'(s >= 0));
        if (s >= 0) begin
            chk("m_op",  iop, mq[s].op);
            chk("m_v1",  iv1, mq[s].v1);
            chk("m_v2",  iv2, mq[s].v2);
            chk("m_tag", 32'(itag), 32'(mq[s].tag));
        end else begin
            chk("m_op0",  iop, 32'd0);
            chk("m_v10",  iv1, 32'd0);
            chk("m_v20",  iv2, 32'd0);
            chk("m_tag0", 32'(itag), 32'd0);
        end
        chk("m_occ",   32'(occ), 32'(mq.size()));
        chk("m_empty", 32'(empty), 32'(mq.size() == 0));
        chk("m_dready", 32'(dready), 32'(mq.size() < 8));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; dv = 0; dop = 0; dv1 = 0; dv2 = 0;
        dq1v = 0; dq2v = 0; dq1 = 0; dq2 = 0; dtag = 0;
        cv = 0; ctag = 0; cdata = 0;
    endtask

    task automatic disp(input logic [31:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic w1,
                        input logic [4:0] t1, input logic w2,
                        input logic [4:0] t2, input logic [4:0] tg);
        dv = 1; dop = op; dv1 = a; dv2 = b;
        dq1v = w1; dq1 = t1; dq2v = w2; dq2 = t2; dtag = tg;
    endtask

    task automatic cdb(input int k, input logic [4:0] t,
                       input logic [31:0] d);
        cv[k] = 1'b1;
        ctag[k*5 +: 5] = t;
        cdata[k*32 +: 32] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        ir = 0;
        #1 rst_ni = 0;
        repeat (2) @(posedge clk);
        #1 rst_ni = 1;
        cyc();
        chk("rst_occ", 32'(occ), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_dready", 32'(dready), 32'd1);
        chk("rst_ivalid", 32'(iv), 32'd0);
        chk("rst_op", iop, 32'd0);

        // 1: simple ready op
        disp(32'h11, 32'd5, 32'd7, 0, 0, 0, 0, 5'd3);
        ir = 1;
        cyc();
        dv = 0;
        chk("t1_valid", 32'(iv), 32'd1);
        chk("t1_rs1", iv1, 32'd5);
        chk("t1_rs2", iv2, 32'd7);
        chk("t1_tag", 32'(itag), 32'd3);
        chk("t1_occ1", 32'(occ), 32'd1);
        cyc();
        chk("t1_occ0", 32'(occ), 32'd0);
        chk("t1_valid0", 32'(iv), 32'd0);

        // 2a: younger B wakes first and issues before A
        ir = 0;
        disp(32'hA, 0, 0, 1, 5'd9, 0, 0, 5'd1);
        cyc();
        disp(32'hB, 0, 0, 1, 5'd10, 0, 0, 5'd2);
        cyc();
        idle();
        cdb(0, 5'd10, 32'hB);
        cyc();
        idle();
        chk("t2_b_tag", 32'(itag), 32'd2);
        chk("t2_b_rs1", iv1, 32'hB);
        cdb(1, 5'd9, 32'hA);
        ir = 1;
        cyc();
        idle();
        chk("t2_a_tag", 32'(itag), 32'd1);
        chk("t2_a_rs1", iv1, 32'hA);
        chk("t2_occ", 32'(occ), 32'd1);
        cyc();
        chk("t2_empty", 32'(empty), 32'd1);

        // 2b: both wake together, older A first
        ir = 0;
        disp(32'hA2, 0, 0, 1, 5'd9, 0, 0, 5'd5);
        cyc();
        disp(32'hB2, 0, 0, 0, 0, 1, 5'd10, 5'd6);
        cyc();
        idle();
        cdb(0, 5'd9, 32'hA);
        cdb(1, 5'd10, 32'hB);
        cyc();
        idle();
        chk("t2b_first", 32'(itag), 32'd5);
        chk("t2b_rs1", iv1, 32'hA);
        ir = 1;
        cyc();
        chk("t2b_second", 32'(itag), 32'd6);
        chk("t2b_rs2", iv2, 32'hB);
        cyc();
        chk("t2b_empty", 32'(empty), 32'd1);

        // 3: dispatch bypass, and lowest bus wins on a double match
        disp(32'h33, 0, 32'h1, 1, 5'd4, 0, 0, 5'd7);
        cdb(1, 5'd4, 32'h55);
        cyc();
        idle();
        chk("t3_valid", 32'(iv), 32'd1);
        chk("t3_rs1", iv1, 32'h55);
        disp(32'h34, 32'h2, 0, 0, 0, 1, 5'd12, 5'd8);
        cdb(0, 5'd12, 32'h66);
        cdb(1, 5'd12, 32'h77);
        cyc();
        idle();
        chk("t3_low_k", iv2, 32'h66);
        cyc();
        chk("t3_empty", 32'(empty), 32'd1);

        // 4: fill, then issue with a blocked dispatch
        ir = 0;
        for (int i = 0; i < 8; i++) begin
            disp(32'h40 + i, i, i + 1, 0, 0, 0, 0, 5'(i));
            cyc();
        end
        chk("t4_full", 32'(dready), 32'd0);
        chk("t4_occ8", 32'(occ), 32'd8);
        chk("t4_oldest", 32'(itag), 32'd0);
        disp(32'h99, 32'h9, 32'h9, 0, 0, 0, 0, 5'd20);
        ir = 1;
        cyc();
        chk("t4_occ7", 32'(occ), 32'd7);
        chk("t4_ready", 32'(dready), 32'd1);
        chk("t4_next", 32'(itag), 32'd1);
        ir = 0;
        cyc();
        dv = 0;
        chk("t4_occ8b", 32'(occ), 32'd8);
        ir = 1;
        for (int n = 0; n < 20 && !empty; n++) cyc();
        chk("t4_drain", 32'(empty), 32'd1);

        // 5: flush with simultaneous handshakes
        ir = 0;
        for (int i = 0; i < 5; i++) begin
            disp(32'h50 + i, i, i, 0, 0, 0, 0, 5'(8 + i));
            cyc();
        end
        dv = 0;
        chk("t5_occ5", 32'(occ), 32'd5);
        flush = 1;
        disp(32'h5F, 1, 1, 0, 0, 0, 0, 5'd30);
        ir = 1;
        cyc();
        idle();
        ir = 0;
        chk("t5_occ0", 32'(occ), 32'd0);
        chk("t5_empty", 32'(empty), 32'd1);
        chk("t5_ivalid", 32'(iv), 32'd0);

        // 6: asynchronous reset between edges
        disp(32'h61, 32'h3, 32'h4, 0, 0, 0, 0, 5'd14);
        cyc();
        disp(32'h62, 32'h5, 32'h6, 0, 0, 0, 0, 5'd15);
        cyc();
        idle();
        chk("t6_pre", 32'(occ), 32'd2);
        #2 rst_ni = 0;
        #1;
        chk("t6_occ", 32'(occ), 32'd0);
        chk("t6_empty", 32'(empty), 32'd1);
        chk("t6_dready", 32'(dready), 32'd1);
        chk("t6_ivalid", 32'(iv), 32'd0);
        chk("t6_rs1", iv1, 32'd0);
        @(posedge clk);
        #1 rst_ni = 1;
        cyc();
        chk("t6_after", 32'(occ), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
